// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: command sequencer for the BCD MM:SS stopwatch datapath.
// It synchronises and edge-detects the front-panel buttons and picks one
// command per cycle by fixed priority. It runs the IDLE/RUN/PAUSED/LIMIT
// machine and produces the speed-scaled count tick. All outputs are
// registered, so every decision appears one cycle after it is made.
module stopwatch_ctrl #(
   parameter int CLK_DIV_BASE = 64,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk_in,
   input  logic       RST_N,
   input  logic       START_BTN,
   input  logic       RESET_BTN,
   input  logic       REVERSE_BTN,
   input  logic       ADD_BTN,
   input  logic       SUB_BTN,
   input  logic       SPD_UP_BTN,
   input  logic       SPD_DN_BTN,
   input  logic       AT_LIMIT,
   output logic       TICK,
   output logic       RUN,
   output logic       DIR,
   output logic       LOAD,
   output logic       LOAD_SEL,
   output logic       ADJ_ADD,
   output logic       ADJ_SUB,
   output logic [1:0] SPEED,
   output logic [1:0] STATE
);

   localparam int NB  = 7;
   localparam int PW  = $clog2(CLK_DIV_BASE);
   localparam int PW1 = PW + 1;
   localparam logic [PW:0] BASE_C = PW1'(CLK_DIV_BASE);

   // One-hot commands; the lowest set bit has the highest priority
   localparam logic [NB-1:0] CMD_RESET   = 7'b0000001;
   localparam logic [NB-1:0] CMD_REVERSE = 7'b0000010;
   localparam logic [NB-1:0] CMD_START   = 7'b0000100;
   localparam logic [NB-1:0] CMD_ADD     = 7'b0001000;
   localparam logic [NB-1:0] CMD_SUB     = 7'b0010000;
   localparam logic [NB-1:0] CMD_SPD_UP  = 7'b0100000;
   localparam logic [NB-1:0] CMD_SPD_DN  = 7'b1000000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSED = 2'b10,
      ST_LIMIT  = 2'b11
   } state_e;

   logic [NB-1:0]                  btn_s;
   logic [SYNC_STAGES-1:0][NB-1:0] sync_q;
   logic [NB-1:0]                  hist_q;
   logic [NB-1:0]                  edge_s;
   logic [NB-1:0]                  grant_s;

   state_e        state_q, state_d;
   logic          dir_q, dir_d;
   logic [1:0]    speed_q, speed_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          init_q;
   logic          tick_q, tick_d;
   logic          load_q, load_d;
   logic          load_sel_q, load_sel_d;
   logic          adj_add_q, adj_add_d;
   logic          adj_sub_q, adj_sub_d;
   logic          run_q;
   logic [PW:0]   period_s;
   logic [PW-1:0] last_s;
   logic          tick_hit_s;

   assign btn_s = {SPD_DN_BTN, SPD_UP_BTN, SUB_BTN, ADD_BTN,
                   START_BTN, REVERSE_BTN, RESET_BTN};

   // Button synchroniser chain plus edge history
   always_ff @(posedge clk_in or negedge RST_N) begin
      if (!RST_N) begin
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_s};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_s  = sync_q[SYNC_STAGES-1] & ~hist_q;
   // Isolating the lowest set bit keeps only the highest-priority edge
   assign grant_s = edge_s & (~edge_s + NB'(1));

   assign period_s   = BASE_C >> speed_q;
   assign last_s     = PW'(period_s - PW1'(1));
   assign tick_hit_s = (state_q == ST_RUN) && (pre_q == last_s);

   // Command decode, state transitions, prescaler and strobe generation
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      speed_d    = speed_q;
      pre_d      = pre_q;
      load_sel_d = load_sel_q;
      load_d     = 1'b0;
      adj_add_d  = 1'b0;
      adj_sub_d  = 1'b0;
      tick_d     = 1'b0;
      if (state_q == ST_RUN) begin
         if (tick_hit_s) begin
            pre_d = '0;
         end else begin
            pre_d = pre_q + PW'(1);
         end
         // At the terminal value the tick is withheld so the count never passes it
         if (AT_LIMIT) begin
            state_d = ST_LIMIT;
            tick_d  = 1'b0;
         end else begin
            tick_d  = tick_hit_s;
         end
      end else begin
         pre_d = pre_q;
      end
      if (!init_q) begin
         load_d     = 1'b1;
         load_sel_d = 1'b0;
      end else begin
         case (grant_s)
            CMD_RESET: begin
               load_d     = 1'b1;
               load_sel_d = dir_q;
               pre_d      = '0;
               state_d    = ST_IDLE;
            end
            CMD_REVERSE: begin
               if (state_q != ST_RUN) begin
                  dir_d      = ~dir_q;
                  load_d     = 1'b1;
                  load_sel_d = ~dir_q;
                  state_d    = ST_IDLE;
               end else begin
                  dir_d      = dir_q;
               end
            end
            CMD_START: begin
               case (state_q)
                  ST_IDLE, ST_PAUSED: begin
                     if (AT_LIMIT) begin
                        state_d = ST_LIMIT;
                     end else begin
                        state_d = ST_RUN;
                     end
                  end
                  ST_RUN: begin
                     if (AT_LIMIT) begin
                        state_d = ST_LIMIT;
                     end else begin
                        state_d = ST_PAUSED;
                     end
                  end
                  default: state_d = state_q;
               endcase
            end
            CMD_ADD, CMD_SUB: begin
               if (state_q != ST_RUN) begin
                  adj_add_d = (grant_s == CMD_ADD);
                  adj_sub_d = (grant_s == CMD_SUB);
                  if (state_q == ST_LIMIT) begin
                     state_d = ST_PAUSED;
                  end else begin
                     state_d = state_q;
                  end
               end else begin
                  adj_add_d = 1'b0;
                  adj_sub_d = 1'b0;
               end
            end
            CMD_SPD_UP: begin
               if (speed_q != 2'd3) begin
                  speed_d = speed_q + 2'd1;
                  pre_d   = '0;
               end else begin
                  speed_d = speed_q;
               end
            end
            CMD_SPD_DN: begin
               if (speed_q != 2'd0) begin
                  speed_d = speed_q - 2'd1;
                  pre_d   = '0;
               end else begin
                  speed_d = speed_q;
               end
            end
            default: begin
               load_d = 1'b0;
            end
         endcase
      end
      // Command strobes win over a coincident tick; the prescaler has already wrapped
      tick_d = tick_d & ~(load_d | adj_add_d | adj_sub_d);
   end

   // State and registered outputs
   always_ff @(posedge clk_in or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         dir_q      <= 1'b0;
         speed_q    <= 2'd0;
         pre_q      <= '0;
         init_q     <= 1'b0;
         tick_q     <= 1'b0;
         load_q     <= 1'b0;
         load_sel_q <= 1'b0;
         adj_add_q  <= 1'b0;
         adj_sub_q  <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         speed_q    <= speed_d;
         pre_q      <= pre_d;
         init_q     <= 1'b1;
         tick_q     <= tick_d;
         load_q     <= load_d;
         load_sel_q <= load_sel_d;
         adj_add_q  <= adj_add_d;
         adj_sub_q  <= adj_sub_d;
         run_q      <= (state_d == ST_RUN);
      end
   end

   assign TICK     = tick_q;
   assign RUN      = run_q;
   assign DIR      = dir_q;
   assign LOAD     = load_q;
   assign LOAD_SEL = load_sel_q;
   assign ADJ_ADD  = adj_add_q;
   assign ADJ_SUB  = adj_sub_q;
   assign SPEED    = speed_q;
   assign STATE    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl: a table of button presses with
// expected strobes and state, plus hand-written multi-cycle sequences.
module tb_stopwatch_ctrl;

   logic       clk_in = 1'b0;
   logic       RST_N = 1'b0;
   logic       START_BTN = 1'b0, RESET_BTN = 1'b0, REVERSE_BTN = 1'b0;
   logic       ADD_BTN = 1'b0, SUB_BTN = 1'b0, SPD_UP_BTN = 1'b0, SPD_DN_BTN = 1'b0;
   logic       AT_LIMIT = 1'b0;
   logic       TICK, RUN, DIR, LOAD, LOAD_SEL, ADJ_ADD, ADJ_SUB;
   logic [1:0] SPEED, STATE;

   int checks = 0;
   int failures = 0;
   int n_load, n_add, n_sub, n_tick, first_strobe;
   logic last_sel;

   // button vector bit order: 0 RESET,1 REVERSE,2 START,3 ADD,4 SUB,5 SPD_UP,6 SPD_DN
   typedef struct {
      logic [6:0] btn;
      logic       lim;
      int         n_load;
      logic       sel;
      int         n_add;
      int         n_sub;
      logic [1:0] st;
      logic       dir;
      logic [1:0] spd;
   } vec_t;

   vec_t vq[$];

   stopwatch_ctrl #(.CLK_DIV_BASE(64), .SYNC_STAGES(2)) dut (
      .clk_in(clk_in), .RST_N(RST_N),
      .START_BTN(START_BTN), .RESET_BTN(RESET_BTN), .REVERSE_BTN(REVERSE_BTN),
      .ADD_BTN(ADD_BTN), .SUB_BTN(SUB_BTN), .SPD_UP_BTN(SPD_UP_BTN),
      .SPD_DN_BTN(SPD_DN_BTN), .AT_LIMIT(AT_LIMIT),
      .TICK(TICK), .RUN(RUN), .DIR(DIR), .LOAD(LOAD), .LOAD_SEL(LOAD_SEL),
      .ADJ_ADD(ADJ_ADD), .ADJ_SUB(ADJ_SUB), .SPEED(SPEED), .STATE(STATE)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic vec_t mk(logic [6:0] b, logic l, int nl, logic s, int na,
                               int ns, logic [1:0] st, logic d, logic [1:0] sp);
      vec_t v;
      v.btn = b; v.lim = l; v.n_load = nl; v.sel = s; v.n_add = na;
      v.n_sub = ns; v.st = st; v.dir = d; v.spd = sp;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_counts();
      n_load = 0; n_add = 0; n_sub = 0; n_tick = 0; first_strobe = -1; last_sel = 1'b0;
   endtask

   task automatic sample_cycle(input int idx);
      @(posedge clk_in);
      @(negedge clk_in);
      if (LOAD) begin
         n_load++;
         last_sel = LOAD_SEL;
      end
      n_add  += int'(ADJ_ADD);
      n_sub  += int'(ADJ_SUB);
      n_tick += int'(TICK);
      if ((LOAD || ADJ_ADD || ADJ_SUB) && first_strobe < 0) first_strobe = idx;
   endtask

   task automatic set_btns(input logic [6:0] b);
      {SPD_DN_BTN, SPD_UP_BTN, SUB_BTN, ADD_BTN, START_BTN, REVERSE_BTN, RESET_BTN} = b;
   endtask

   // press the given buttons (from a negedge), hold, release, then check
   task automatic run_vec(input string nm, input vec_t v);
      AT_LIMIT = v.lim;
      clear_counts();
      set_btns(v.btn);
      for (int i = 1; i <= 6; i++) sample_cycle(i);
      set_btns(7'd0);
      for (int i = 7; i <= 9; i++) sample_cycle(i);
      chk({nm, " load_count"}, n_load, v.n_load);
      if (v.n_load > 0) chk({nm, " load_sel"}, int'(last_sel), int'(v.sel));
      chk({nm, " adj_add_count"}, n_add, v.n_add);
      chk({nm, " adj_sub_count"}, n_sub, v.n_sub);
      chk({nm, " state"}, int'(STATE), int'(v.st));
      chk({nm, " run"}, int'(RUN), int'(v.st == 2'b01));
      chk({nm, " dir"}, int'(DIR), int'(v.dir));
      chk({nm, " speed"}, int'(SPEED), int'(v.spd));
      if (v.n_load + v.n_add + v.n_sub > 0) chk({nm, " strobe_latency"}, first_strobe, 3);
   endtask

   // release reset and watch 200 cycles for the single initial load
   task automatic reset_release(input string nm);
      int first_load;
      first_load = -1;
      @(negedge clk_in);
      RST_N = 1'b1;
      clear_counts();
      for (int i = 1; i <= 200; i++) begin
         sample_cycle(i);
         if (LOAD && first_load < 0) first_load = i;
      end
      chk({nm, " load_count"}, n_load, 1);
      chk({nm, " load_first_cycle"}, first_load, 1);
      chk({nm, " load_sel"}, int'(last_sel), 0);
      chk({nm, " tick_count"}, n_tick, 0);
      chk({nm, " state"}, int'(STATE), 0);
      chk({nm, " speed"}, int'(SPEED), 0);
      chk({nm, " dir"}, int'(DIR), 0);
   endtask

   // count cycles until TICK is seen high, giving up after bound cycles
   task automatic wait_tick(input int bound, output int n);
      n = 0;
      do begin
         @(posedge clk_in);
         @(negedge clk_in);
         n++;
      end while (!TICK && n < bound);
      if (!TICK) n = -1;
   endtask

   initial begin
      int n;
      // 0 IDLE, 1 RUN, 2 PAUSED, 3 LIMIT
      vq.push_back(mk(7'b0001000, 1'b0, 0, 1'b0, 1, 0, 2'd0, 1'b0, 2'd0)); // ADD idle
      vq.push_back(mk(7'b0010000, 1'b0, 0, 1'b0, 0, 1, 2'd0, 1'b0, 2'd0)); // SUB idle
      vq.push_back(mk(7'b0000100, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b0, 2'd0)); // START -> RUN
      vq.push_back(mk(7'b0001000, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b0, 2'd0)); // ADD in RUN
      vq.push_back(mk(7'b0010000, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b0, 2'd0)); // SUB in RUN
      vq.push_back(mk(7'b0000010, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b0, 2'd0)); // REVERSE in RUN
      vq.push_back(mk(7'b0000100, 1'b0, 0, 1'b0, 0, 0, 2'd2, 1'b0, 2'd0)); // START -> PAUSED
      vq.push_back(mk(7'b0001000, 1'b0, 0, 1'b0, 1, 0, 2'd2, 1'b0, 2'd0)); // ADD paused
      vq.push_back(mk(7'b0010000, 1'b0, 0, 1'b0, 0, 1, 2'd2, 1'b0, 2'd0)); // SUB paused
      vq.push_back(mk(7'b0100000, 1'b0, 0, 1'b0, 0, 0, 2'd2, 1'b0, 2'd1)); // SPD_UP
      vq.push_back(mk(7'b1000000, 1'b0, 0, 1'b0, 0, 0, 2'd2, 1'b0, 2'd0)); // SPD_DN
      vq.push_back(mk(7'b1000000, 1'b0, 0, 1'b0, 0, 0, 2'd2, 1'b0, 2'd0)); // SPD_DN floor
      vq.push_back(mk(7'b0000010, 1'b0, 1, 1'b1, 0, 0, 2'd0, 1'b1, 2'd0)); // REVERSE paused
      vq.push_back(mk(7'b0000001, 1'b0, 1, 1'b1, 0, 0, 2'd0, 1'b1, 2'd0)); // RESET
      vq.push_back(mk(7'b0001101, 1'b0, 1, 1'b1, 0, 0, 2'd0, 1'b1, 2'd0)); // RESET+START+ADD
      vq.push_back(mk(7'b0000100, 1'b1, 0, 1'b0, 0, 0, 2'd3, 1'b1, 2'd0)); // START at limit
      vq.push_back(mk(7'b0000100, 1'b1, 0, 1'b0, 0, 0, 2'd3, 1'b1, 2'd0)); // START in LIMIT
      vq.push_back(mk(7'b0001000, 1'b1, 0, 1'b0, 1, 0, 2'd2, 1'b1, 2'd0)); // ADD in LIMIT
      vq.push_back(mk(7'b0000010, 1'b0, 1, 1'b0, 0, 0, 2'd0, 1'b0, 2'd0)); // REVERSE
      vq.push_back(mk(7'b1100000, 1'b0, 0, 1'b0, 0, 0, 2'd0, 1'b0, 2'd1)); // SPD_UP beats SPD_DN
      vq.push_back(mk(7'b0000110, 1'b0, 1, 1'b1, 0, 0, 2'd0, 1'b1, 2'd1)); // REVERSE beats START
      vq.push_back(mk(7'b0000010, 1'b0, 1, 1'b0, 0, 0, 2'd0, 1'b0, 2'd1)); // REVERSE

      // reset state while RST_N is held low
      repeat (3) @(negedge clk_in);
      chk("reset outputs", int'({TICK, RUN, DIR, LOAD, LOAD_SEL, ADJ_ADD, ADJ_SUB, SPEED, STATE}), 0);
      reset_release("reset_release");

      foreach (vq[i]) run_vec($sformatf("vec%0d", i), vq[i]);

      // tick period at speed 0 and speed 3
      run_vec("spd_dn_to_0", mk(7'b1000000, 1'b0, 0, 1'b0, 0, 0, 2'd0, 1'b0, 2'd0));
      run_vec("start_run",   mk(7'b0000100, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b0, 2'd0));
      wait_tick(200, n);
      chk("tick_found_spd0", int'(n > 0), 1);
      wait_tick(200, n);
      chk("tick_period_spd0", n, 64);
      run_vec("spd_up1", mk(7'b0100000, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b0, 2'd1));
      run_vec("spd_up2", mk(7'b0100000, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b0, 2'd2));
      run_vec("spd_up3", mk(7'b0100000, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b0, 2'd3));
      wait_tick(200, n);
      chk("tick_found_spd3", int'(n > 0), 1);
      wait_tick(200, n);
      chk("tick_period_spd3", n, 8);
      run_vec("spd_up_sat", mk(7'b0100000, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b0, 2'd3));

      // AT_LIMIT raised exactly in the cycle the prescaler would tick
      wait_tick(50, n);
      chk("tick_found_pre_limit", int'(n > 0), 1);
      repeat (7) @(posedge clk_in);
      @(negedge clk_in);
      AT_LIMIT = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      chk("limit tick_suppressed", int'(TICK), 0);
      chk("limit state", int'(STATE), 3);
      chk("limit run", int'(RUN), 0);
      run_vec("limit_start_ignored", mk(7'b0000100, 1'b1, 0, 1'b0, 0, 0, 2'd3, 1'b0, 2'd3));
      run_vec("limit_reverse",       mk(7'b0000010, 1'b1, 1, 1'b1, 0, 0, 2'd0, 1'b1, 2'd3));

      // asynchronous reset in the middle of RUN
      run_vec("start_before_rst", mk(7'b0000100, 1'b0, 0, 1'b0, 0, 0, 2'd1, 1'b1, 2'd3));
      repeat (5) @(posedge clk_in);
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_reset outputs", int'({TICK, RUN, DIR, LOAD, LOAD_SEL, ADJ_ADD, ADJ_SUB, SPEED, STATE}), 0);
      repeat (2) @(negedge clk_in);
      reset_release("reset_release2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
